// File: rtl/mul_seq_ctrl.sv
// Issue/sequencing controller for the pipelined Wallace-tree multiplier: sets operand
// signedness, launches into the fixed-latency datapath, selects the result half, caches the last product.
module mul_seq_ctrl #(
    parameter int DataWidth   = 64,
    parameter int PipeLatency = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     MulReqValid,
    output logic                     MulReqReady,
    input  logic [2:0]               MulOp,
    input  logic [DataWidth-1:0]     Rs1Data,
    input  logic [DataWidth-1:0]     Rs2Data,
    input  logic [4:0]               RdAddr,
    input  logic                     Flush,
    output logic                     PipeLaunch,
    output logic [DataWidth-1:0]     PipeOpA,
    output logic [DataWidth-1:0]     PipeOpB,
    output logic                     PipeSignedA,
    output logic                     PipeSignedB,
    input  logic [2*DataWidth-1:0]   PipeSum,
    output logic                     MulHoldToEx,
    output logic                     MulRespValid,
    output logic [DataWidth-1:0]     MulResult,
    output logic [4:0]               MulRespRdAddr,
    output logic [1:0]               DbgState
);

    // Handshake: a request transfers in a cycle where MulReqValid and MulReqReady are both
    // high; EX keeps the request stable while it is held. Ready drops combinationally on Flush.

    localparam int CntW = $clog2(PipeLatency + 1);

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpMulw   = 3'b100;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_t;

    state_t                   state;
    logic [CntW-1:0]          cnt;
    logic [2:0]               opReg;
    logic [4:0]               tagReg;
    logic [DataWidth-1:0]     rs1Reg;
    logic [DataWidth-1:0]     rs2Reg;
    logic                     signedAReg;
    logic                     signedBReg;
    logic [DataWidth-1:0]     resultReg;

    logic                     cacheValid;
    logic [2*DataWidth-1:0]   cacheSum;
    logic [DataWidth-1:0]     cacheA;
    logic [DataWidth-1:0]     cacheB;
    logic                     cacheSignedA;
    logic                     cacheSignedB;

    logic [2:0]               reqOp;
    logic                     reqIsW;
    logic                     reqSignedA;
    logic                     reqSignedB;
    logic [DataWidth-1:0]     reqOpA;
    logic [DataWidth-1:0]     reqOpB;
    logic                     hit;
    logic                     accept;
    logic                     launch;

    function automatic logic [DataWidth-1:0] selectHalf(input logic [2*DataWidth-1:0] sum,
                                                        input logic [2:0] op);
        logic [DataWidth-1:0] r;
        case (op)
            OpMul:   r = sum[DataWidth-1:0];
            OpMulw:  r = {{(DataWidth-32){sum[31]}}, sum[31:0]};
            default: r = sum[2*DataWidth-1:DataWidth];
        endcase
        return r;
    endfunction

    // Illegal encodings execute as MUL.
    always_comb begin
        reqOp      = (MulOp > OpMulw) ? OpMul : MulOp;
        reqIsW     = (reqOp == OpMulw);
        reqSignedA = (reqOp != OpMulhu);
        reqSignedB = (reqOp == OpMul) || (reqOp == OpMulh) || (reqOp == OpMulw);
        reqOpA     = reqIsW ? {{(DataWidth-32){Rs1Data[31]}}, Rs1Data[31:0]} : Rs1Data;
        reqOpB     = reqIsW ? {{(DataWidth-32){Rs2Data[31]}}, Rs2Data[31:0]} : Rs2Data;
        // MUL's low half does not depend on signedness, so any cached pair serves it.
        hit        = cacheValid && !reqIsW && (Rs1Data == cacheA) && (Rs2Data == cacheB) &&
                     ((reqOp == OpMul) ||
                      ((reqSignedA == cacheSignedA) && (reqSignedB == cacheSignedB)));
        accept     = (state == StIdle) && MulReqValid && !Flush;
        launch     = accept && !hit;
    end

    assign MulReqReady   = (state == StIdle) && !Flush;
    assign PipeLaunch    = launch;
    assign PipeOpA       = launch ? reqOpA : '0;
    assign PipeOpB       = launch ? reqOpB : '0;
    assign PipeSignedA   = launch && reqSignedA;
    assign PipeSignedB   = launch && reqSignedB;
    assign MulHoldToEx   = (state == StBusy) || (state == StDrain) || launch;
    assign MulRespValid  = (state == StDone) && !Flush;
    assign MulResult     = resultReg;
    assign MulRespRdAddr = tagReg;
    assign DbgState      = state;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= StIdle;
            cnt          <= '0;
            opReg        <= '0;
            tagReg       <= '0;
            rs1Reg       <= '0;
            rs2Reg       <= '0;
            signedAReg   <= 1'b0;
            signedBReg   <= 1'b0;
            resultReg    <= '0;
            cacheValid   <= 1'b0;
            cacheSum     <= '0;
            cacheA       <= '0;
            cacheB       <= '0;
            cacheSignedA <= 1'b0;
            cacheSignedB <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        opReg  <= reqOp;
                        tagReg <= RdAddr;
                        if (hit) begin
                            resultReg <= selectHalf(cacheSum, reqOp);
                            state     <= StDone;
                        end else begin
                            rs1Reg     <= Rs1Data;
                            rs2Reg     <= Rs2Data;
                            signedAReg <= reqSignedA;
                            signedBReg <= reqSignedB;
                            cnt        <= CntW'(PipeLatency);
                            state      <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    cnt <= cnt - CntW'(1);
                    if (Flush) begin
                        // The in-flight product is dropped; the drain only waits it out.
                        state <= (cnt == CntW'(1)) ? StIdle : StDrain;
                    end else if (cnt == CntW'(1)) begin
                        resultReg <= selectHalf(PipeSum, opReg);
                        if (opReg != OpMulw) begin
                            cacheValid   <= 1'b1;
                            cacheSum     <= PipeSum;
                            cacheA       <= rs1Reg;
                            cacheB       <= rs2Reg;
                            cacheSignedA <= signedAReg;
                            cacheSignedB <= signedBReg;
                        end
                        state <= StDone;
                    end
                end
                StDrain: begin
                    cnt <= cnt - CntW'(1);
                    if (cnt == CntW'(1)) state <= StIdle;
                end
                StDone: begin
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: models the fixed-latency datapath, replays a vector table,
// hand-written flush/reset sequences, then random requests against an arithmetic reference.
module tb_mul_seq_ctrl;

    localparam int DW  = 64;
    localparam int LAT = 4;

    logic            Clk = 1'b0;
    logic            Rst;
    logic            MulReqValid;
    logic            MulReqReady;
    logic [2:0]      MulOp;
    logic [DW-1:0]   Rs1Data;
    logic [DW-1:0]   Rs2Data;
    logic [4:0]      RdAddr;
    logic            Flush;
    logic            PipeLaunch;
    logic [DW-1:0]   PipeOpA;
    logic [DW-1:0]   PipeOpB;
    logic            PipeSignedA;
    logic            PipeSignedB;
    logic [2*DW-1:0] PipeSum;
    logic            MulHoldToEx;
    logic            MulRespValid;
    logic [DW-1:0]   MulResult;
    logic [4:0]      MulRespRdAddr;
    logic [1:0]      DbgState;

    mul_seq_ctrl #(.DataWidth(DW), .PipeLatency(LAT)) dut (
        .Clk(Clk), .Rst(Rst), .MulReqValid(MulReqValid), .MulReqReady(MulReqReady),
        .MulOp(MulOp), .Rs1Data(Rs1Data), .Rs2Data(Rs2Data), .RdAddr(RdAddr), .Flush(Flush),
        .PipeLaunch(PipeLaunch), .PipeOpA(PipeOpA), .PipeOpB(PipeOpB),
        .PipeSignedA(PipeSignedA), .PipeSignedB(PipeSignedB), .PipeSum(PipeSum),
        .MulHoldToEx(MulHoldToEx), .MulRespValid(MulRespValid), .MulResult(MulResult),
        .MulRespRdAddr(MulRespRdAddr), .DbgState(DbgState)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Datapath model: product of the launched operands appears PipeLatency cycles later,
    // junk otherwise so a mistimed capture is visible.
    logic [2*DW-1:0] dpPipe [LAT];

    function automatic logic [2*DW-1:0] dp_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic sa, input logic sb);
        logic [2*DW-1:0] ea;
        logic [2*DW-1:0] eb;
        ea = sa ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
        eb = sb ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
        return ea * eb;
    endfunction

    always @(posedge Clk) begin
        dpPipe[0] <= PipeLaunch ? dp_mul(PipeOpA, PipeOpB, PipeSignedA, PipeSignedB)
                                : {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i < LAT; i++) dpPipe[i] <= dpPipe[i-1];
    end
    assign PipeSum = dpPipe[LAT-1];

    // Reference model: operation semantics and the cache of the last full product.
    logic          mc_valid;
    logic [DW-1:0] mc_a, mc_b;
    logic          mc_sa, mc_sb;

    function automatic logic [2:0] m_norm(input logic [2:0] op);
        return (op > 3'd4) ? 3'd0 : op;
    endfunction
    function automatic logic m_sa(input logic [2:0] op);
        return m_norm(op) != 3'd3;
    endfunction
    function automatic logic m_sb(input logic [2:0] op);
        logic [2:0] n;
        n = m_norm(op);
        return (n == 3'd0) || (n == 3'd1) || (n == 3'd4);
    endfunction
    function automatic bit model_hit(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2:0] n;
        n = m_norm(op);
        return mc_valid && (n != 3'd4) && (a == mc_a) && (b == mc_b) &&
               ((n == 3'd0) || ((m_sa(op) == mc_sa) && (m_sb(op) == mc_sb)));
    endfunction
    function automatic logic [DW-1:0] ref_result(input logic [2:0] op, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        logic signed [127:0] x, y, p;
        logic signed [63:0]  w;
        logic [DW-1:0]       r;
        case (m_norm(op))
            3'd0: begin x = $signed(a); y = $signed(b); p = x * y; r = p[63:0]; end
            3'd1: begin x = $signed(a); y = $signed(b); p = x * y; r = p[127:64]; end
            3'd2: begin x = $signed(a); y = {64'd0, b}; p = x * y; r = p[127:64]; end
            3'd3: begin x = {64'd0, a}; y = {64'd0, b}; p = x * y; r = p[127:64]; end
            default: begin
                w = $signed(a[31:0]) * $signed(b[31:0]);
                r = {{32{w[31]}}, w[31:0]};
            end
        endcase
        return r;
    endfunction
    function automatic logic [DW-1:0] ref_opnd(input logic [2:0] op, input logic [DW-1:0] v);
        return (m_norm(op) == 3'd4) ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    // Issue one request from IDLE and follow it to its response.
    task automatic do_req(input string nm, input logic [2:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [4:0] tag, input bit exp_hit,
                          input logic [DW-1:0] exp_res, input logic [DW-1:0] exp_pa,
                          input logic [DW-1:0] exp_pb, input logic exp_sa, input logic exp_sb);
        int lat;
        bit got;
        MulReqValid = 1'b1;
        MulOp = op;
        Rs1Data = a;
        Rs2Data = b;
        RdAddr = tag;
        @(negedge Clk);
        chk({nm, " ready"}, MulReqReady, 1);
        chk({nm, " launch"}, PipeLaunch, !exp_hit);
        chk({nm, " hold_accept"}, MulHoldToEx, !exp_hit);
        if (!exp_hit) begin
            chk({nm, " opA"}, PipeOpA, exp_pa);
            chk({nm, " opB"}, PipeOpB, exp_pb);
            chk({nm, " signedA"}, PipeSignedA, exp_sa);
            chk({nm, " signedB"}, PipeSignedB, exp_sb);
        end
        next_cycle();
        MulReqValid = 1'b0;
        MulOp = 3'($urandom);
        Rs1Data = {$urandom, $urandom};
        Rs2Data = {$urandom, $urandom};
        RdAddr = 5'($urandom);
        lat = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clk);
            if (MulRespValid) begin
                got = 1;
            end else begin
                chk({nm, " hold_busy"}, MulHoldToEx, 1);
                chk({nm, " ready_busy"}, MulReqReady, 0);
                next_cycle();
                lat++;
            end
        end
        chk({nm, " resp_seen"}, got, 1);
        if (got) begin
            chk({nm, " latency"}, lat, exp_hit ? 1 : LAT + 1);
            chk({nm, " result"}, MulResult, exp_res);
            chk({nm, " tag"}, MulRespRdAddr, tag);
            chk({nm, " hold_done"}, MulHoldToEx, 0);
            next_cycle();
            if (!exp_hit && m_norm(op) != 3'd4) begin
                mc_valid = 1'b1;
                mc_a = a;
                mc_b = b;
                mc_sa = m_sa(op);
                mc_sb = m_sb(op);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " ready"}, MulReqReady, 1);
        chk({nm, " launch"}, PipeLaunch, 0);
        chk({nm, " opA"}, PipeOpA, 0);
        chk({nm, " opB"}, PipeOpB, 0);
        chk({nm, " signed"}, {PipeSignedA, PipeSignedB}, 0);
        chk({nm, " hold"}, MulHoldToEx, 0);
        chk({nm, " resp"}, MulRespValid, 0);
        chk({nm, " result"}, MulResult, 0);
        chk({nm, " tag"}, MulRespRdAddr, 0);
        chk({nm, " state"}, DbgState, 0);
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] a, b;
        bit            hit;
        logic [DW-1:0] res, pa, pb;
        logic          sa, sb;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [DW-1:0] fa, fb, ra, rb, last_a, last_b;
        logic [2:0]    rop;
        int            sel;

        tbl[0]  = '{3'd0, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'hFFFF_FFFF_FFFF_FFFA,
                    64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1};
        tbl[1]  = '{3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 0, 64'h1,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b0, 1'b0};
        tbl[2]  = '{3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1, 64'hFFFF_FFFF_FFFF_FFFE,
                    64'h0, 64'h0, 1'b0, 1'b0};
        tbl[3]  = '{3'd1, 64'h8000_0000_0000_0000, 64'h2, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0000, 64'h2, 1'b1, 1'b1};
        tbl[4]  = '{3'd3, 64'h8000_0000_0000_0000, 64'h2, 0, 64'h1,
                    64'h8000_0000_0000_0000, 64'h2, 1'b0, 1'b0};
        tbl[5]  = '{3'd4, 64'h1_0000_0007, 64'h1_FFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFF9,
                    64'h7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        tbl[6]  = '{3'd3, 64'h8000_0000_0000_0000, 64'h2, 1, 64'h1,
                    64'h0, 64'h0, 1'b0, 1'b0};
        tbl[7]  = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b1, 1'b0};
        tbl[8]  = '{3'd5, 64'h3, 64'h5, 0, 64'd15, 64'h3, 64'h5, 1'b1, 1'b1};
        tbl[9]  = '{3'd0, 64'h3, 64'h5, 1, 64'd15, 64'h0, 64'h0, 1'b0, 1'b0};
        tbl[10] = '{3'd1, 64'h3, 64'h5, 1, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0};

        Rst = 1'b0;
        MulReqValid = 1'b0;
        MulOp = '0;
        Rs1Data = '0;
        Rs2Data = '0;
        RdAddr = '0;
        Flush = 1'b0;
        mc_valid = 1'b0;
        mc_a = '0;
        mc_b = '0;
        mc_sa = 1'b0;
        mc_sb = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk_reset_outputs("reset");
        Rst = 1'b1;
        next_cycle();

        for (int i = 0; i < 11; i++) begin
            do_req($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 1), tbl[i].hit,
                   tbl[i].res, tbl[i].pa, tbl[i].pb, tbl[i].sa, tbl[i].sb);
        end

        // Flush two cycles after launch: drain, no response, cache untouched.
        fa = 64'h1234_5678_9ABC_DEF0;
        fb = 64'h0FED_CBA9_8765_4321;
        MulReqValid = 1'b1; MulOp = 3'd1; Rs1Data = fa; Rs2Data = fb; RdAddr = 5'd20;
        @(negedge Clk);
        chk("flush_busy launch", PipeLaunch, 1);
        next_cycle();
        MulReqValid = 1'b0;
        @(negedge Clk);
        chk("flush_busy ready_c1", MulReqReady, 0);
        next_cycle();
        Flush = 1'b1;
        @(negedge Clk);
        chk("flush_busy resp_c2", MulRespValid, 0);
        next_cycle();
        Flush = 1'b0;
        for (int c = 3; c <= 8; c++) begin
            @(negedge Clk);
            chk($sformatf("flush_busy ready_c%0d", c), MulReqReady, (c >= 5) ? 1 : 0);
            chk($sformatf("flush_busy hold_c%0d", c), MulHoldToEx, (c >= 5) ? 0 : 1);
            chk($sformatf("flush_busy resp_c%0d", c), MulRespValid, 0);
            next_cycle();
        end
        chk("flush_busy model_miss", model_hit(3'd1, fa, fb), 0);
        do_req("flush_retry", 3'd1, fa, fb, 5'd21, model_hit(3'd1, fa, fb), ref_result(3'd1, fa, fb),
               fa, fb, 1'b1, 1'b1);

        // Flush in IDLE: a would-be hit is not accepted.
        MulReqValid = 1'b1; MulOp = 3'd0; Rs1Data = fa; Rs2Data = fb; RdAddr = 5'd22; Flush = 1'b1;
        @(negedge Clk);
        chk("flush_idle ready", MulReqReady, 0);
        chk("flush_idle launch", PipeLaunch, 0);
        chk("flush_idle hold", MulHoldToEx, 0);
        next_cycle();
        MulReqValid = 1'b0; Flush = 1'b0;
        @(negedge Clk);
        chk("flush_idle no_resp", MulRespValid, 0);
        chk("flush_idle ready_after", MulReqReady, 1);
        next_cycle();

        // Flush in DONE on a cache hit: response suppressed, back to IDLE.
        MulReqValid = 1'b1; MulOp = 3'd0; Rs1Data = fa; Rs2Data = fb; RdAddr = 5'd23;
        @(negedge Clk);
        chk("flush_done launch", PipeLaunch, 0);
        next_cycle();
        MulReqValid = 1'b0; Flush = 1'b1;
        @(negedge Clk);
        chk("flush_done resp", MulRespValid, 0);
        next_cycle();
        Flush = 1'b0;
        @(negedge Clk);
        chk("flush_done ready_after", MulReqReady, 1);
        chk("flush_done no_resp_after", MulRespValid, 0);
        next_cycle();

        // Asynchronous reset while BUSY clears everything, including the cache.
        MulReqValid = 1'b1; MulOp = 3'd0; Rs1Data = 64'h11; Rs2Data = 64'h22; RdAddr = 5'd24;
        @(negedge Clk);
        chk("rst_busy launch", PipeLaunch, 1);
        next_cycle();
        MulReqValid = 1'b0;
        next_cycle();
        #2;
        Rst = 1'b0;
        #1;
        chk_reset_outputs("rst_busy");
        @(negedge Clk);
        Rst = 1'b1;
        mc_valid = 1'b0;
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            chk($sformatf("rst_busy no_resp%0d", c), MulRespValid, 0);
            next_cycle();
        end
        do_req("rst_relaunch", 3'd0, fa, fb, 5'd25, 0, ref_result(3'd0, fa, fb), fa, fb, 1'b1, 1'b1);

        // Random requests with frequent operand reuse to exercise the cache.
        last_a = fa;
        last_b = fb;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                ra = last_a; rb = last_b;
            end else if (sel == 1) begin
                ra = 64'($urandom_range(0, 15)); rb = {$urandom, $urandom};
            end else begin
                ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            end
            rop = 3'($urandom_range(0, 7));
            do_req($sformatf("rand%0d", n), rop, ra, rb, 5'($urandom), model_hit(rop, ra, rb),
                   ref_result(rop, ra, rb), ref_opnd(rop, ra), ref_opnd(rop, rb),
                   m_sa(rop), m_sb(rop));
            last_a = ra;
            last_b = rb;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
